// File: rtl/spart_bus_driver.sv
// spart_bus_driver: SPART host driver; programs the baud divisor, then echoes received bytes through a FIFO.
// Optional SPART_DRV_CASEFOLD_EN: echoed 'a'..'z' are written out as uppercase.
module spart_bus_driver #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD0       = 4800,
   parameter int BAUD1       = 9600,
   parameter int BAUD2       = 19200,
   parameter int BAUD3       = 38400,
   parameter int OVERSAMPLE  = 16,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [1:0]                    br_cfg,
   input  logic                          rda,
   input  logic                          tbr,
   output logic                          iocs,
   output logic                          iorw,
   output logic [1:0]                    ioaddr,
   inout  wire  [7:0]                    databus,
   output logic                          cfg_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [15:0] DIV0 = 16'(CLK_FREQ_HZ / (OVERSAMPLE * BAUD0) - 1);
   localparam logic [15:0] DIV1 = 16'(CLK_FREQ_HZ / (OVERSAMPLE * BAUD1) - 1);
   localparam logic [15:0] DIV2 = 16'(CLK_FREQ_HZ / (OVERSAMPLE * BAUD2) - 1);
   localparam logic [15:0] DIV3 = 16'(CLK_FREQ_HZ / (OVERSAMPLE * BAUD3) - 1);

   typedef enum logic [2:0] {CFG_LO, CFG_HI, RUN, RD, WR, GAP} state_t;

   state_t          state_q, state_d;
   logic            started_q;
   logic [1:0]      br_meta_q, br_sync_q, cfg_sel_q;
   logic            last_rd_q;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PW-1:0]   wp_q, rp_q;
   logic [CW-1:0]   cnt_q;
   logic [15:0]     div;
   logic [7:0]      head, tx_byte, dout;
   logic            empty, full, tx_ok, push, pop, enter_cfg, drive;

   // Switch synchroniser is unreset so it already tracks br_cfg when reset releases.
   always_ff @(posedge clk) begin
      br_meta_q <= br_cfg;
      br_sync_q <= br_meta_q;
   end

   assign empty = cnt_q == '0;
   assign full  = cnt_q == CW'(FIFO_DEPTH);
   assign tx_ok = tbr & ~empty;
   assign head  = mem_q[rp_q];
`ifdef SPART_DRV_CASEFOLD_EN
   assign tx_byte = (head >= 8'h61 && head <= 8'h7A) ? (head & 8'hDF) : head;
`else
   assign tx_byte = head;
`endif
   assign div = cfg_sel_q == 2'd0 ? DIV0 : cfg_sel_q == 2'd1 ? DIV1 : cfg_sel_q == 2'd2 ? DIV2 : DIV3;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         CFG_LO:  state_d = CFG_HI;
         CFG_HI:  state_d = GAP;
         RD, WR:  state_d = GAP;
         GAP:     state_d = RUN;
         RUN:     state_d = (br_sync_q != cfg_sel_q && empty) ? CFG_LO
                          : (rda & ~full & (~last_rd_q | ~tx_ok)) ? RD
                          : tx_ok ? WR : RUN;
         default: state_d = CFG_LO;
      endcase
   end

   assign push      = state_q == RD;
   assign pop       = state_q == WR;
   assign enter_cfg = ~started_q | (state_q == RUN && state_d == CFG_LO);

   // Bus strobes stay low until the first clock after reset release.
   assign iocs     = started_q && (state_q == CFG_LO || state_q == CFG_HI || state_q == RD || state_q == WR);
   assign iorw     = ~(iocs && state_q != RD);
   assign ioaddr   = !started_q ? 2'b00 : state_q == CFG_LO ? 2'b10 : state_q == CFG_HI ? 2'b11 : 2'b00;
   assign dout     = state_q == CFG_LO ? div[7:0] : state_q == CFG_HI ? div[15:8] : tx_byte;
   assign drive    = iocs & ~iorw;
   assign databus  = drive ? dout : 8'bz;
   assign cfg_done = state_q == RUN;
   assign fifo_count = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= CFG_LO;
         started_q <= 1'b0;
         cfg_sel_q <= 2'b00;
         last_rd_q <= 1'b0;
         wp_q      <= '0;
         rp_q      <= '0;
         cnt_q     <= '0;
      end else begin
         started_q <= 1'b1;
         if (started_q) state_q <= state_d;
         if (enter_cfg) cfg_sel_q <= br_sync_q;
         if (push) begin
            wp_q      <= wp_q + 1'b1;
            cnt_q     <= cnt_q + 1'b1;
            last_rd_q <= 1'b1;
         end else if (pop) begin
            rp_q      <= rp_q + 1'b1;
            cnt_q     <= cnt_q - 1'b1;
            last_rd_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wp_q] <= databus;
   end
endmodule
